// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer with imem handshake.
// Optional retired-instruction counter: define SEQ_PERF_COUNTER_EN.
module multicycle_sequencer #(
    parameter logic [3:0] HALT_OP = 4'b1111,
    parameter int         CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             imem_ready,
    input  logic [3:0]       opcode,
    input  logic             RegWrite,
    input  logic             ALUSrc,
    input  logic             Branch,
    input  logic [1:0]       ALUControl,
    input  logic             zero,
    output logic             imem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic             ALUSrcSel,
    output logic [1:0]       ALUOp,
    output logic             RegWriteEn,
    output logic             busy,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DEC   = 3'd2,
        S_EXE   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t     cur, nxt;
    logic       rw_q, src_q, br_q;
    logic [1:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_IDLE;
        else        cur <= nxt;
    end

    // Decode is latched once so EXECUTE/WRITEBACK ignore later IR changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw_q  <= 1'b0;
            src_q <= 1'b0;
            br_q  <= 1'b0;
            op_q  <= 2'b00;
        end else if (cur == S_DEC && opcode != HALT_OP) begin
            rw_q  <= RegWrite;
            src_q <= ALUSrc;
            br_q  <= Branch;
            op_q  <= ALUControl;
        end
    end

    always_comb begin
        nxt        = cur;
        imem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        PCSrc      = 1'b0;
        RegWriteEn = 1'b0;
        unique case (cur)
            S_IDLE: if (start) nxt = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    nxt     = S_DEC;
                end
            end
            S_DEC: nxt = (opcode == HALT_OP) ? S_HALT : S_EXE;
            S_EXE: begin
                if (br_q) begin
                    PCWrite = zero;
                    PCSrc   = zero;
                    nxt     = S_FETCH;
                end else if (rw_q) begin
                    nxt = S_WB;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_WB: begin
                RegWriteEn = 1'b1;
                nxt        = S_FETCH;
            end
            S_HALT: nxt = S_HALT;
            default: nxt = S_IDLE;
        endcase
    end

    assign ALUSrcSel = src_q;
    assign ALUOp     = op_q;
    assign busy      = (cur != S_IDLE) && (cur != S_HALT);
    assign halted    = (cur == S_HALT);
    assign state     = cur;

`ifdef SEQ_PERF_COUNTER_EN
    logic             retire;
    logic [CNT_W-1:0] cnt_q;

    assign retire = (cur == S_WB) || (cur == S_EXE && (br_q || !rw_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cnt_q <= '0;
        else if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign retired_count = cnt_q;
`else
    assign retired_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (CNT_W=4).
// Expected counter values depend on SEQ_PERF_COUNTER_EN.
module tb_multicycle_sequencer;

    logic       clk = 1'b0;
    logic       rst_n, start, imem_ready;
    logic [3:0] opcode;
    logic       RegWrite, ALUSrc, Branch, zero;
    logic [1:0] ALUControl;
    logic       imem_req, IRWrite, PCWrite, PCSrc, ALUSrcSel;
    logic [1:0] ALUOp;
    logic       RegWriteEn, busy, halted;
    logic [2:0] state;
    logic [3:0] retired_count;

    int cmps  = 0;
    int fails = 0;

`ifdef SEQ_PERF_COUNTER_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {state, imem_req, IRWrite, PCWrite, PCSrc, RegWriteEn, busy, halted}
    localparam logic [9:0] E_IDLE = {3'd0, 7'b0000000};
    localparam logic [9:0] E_FRDY = {3'd1, 7'b1110010};
    localparam logic [9:0] E_FWT  = {3'd1, 7'b1000010};
    localparam logic [9:0] E_DEC  = {3'd2, 7'b0000010};
    localparam logic [9:0] E_EX   = {3'd3, 7'b0000010};
    localparam logic [9:0] E_EXT  = {3'd3, 7'b0011010};
    localparam logic [9:0] E_WB   = {3'd4, 7'b0000110};
    localparam logic [9:0] E_HALT = {3'd5, 7'b0000001};

    logic [9:0] obs;
    assign obs = {state, imem_req, IRWrite, PCWrite, PCSrc,
                  RegWriteEn, busy, halted};

    always #5 clk = ~clk;

    multicycle_sequencer #(.HALT_OP(4'b1111), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_ready(imem_ready), .opcode(opcode),
        .RegWrite(RegWrite), .ALUSrc(ALUSrc), .Branch(Branch),
        .ALUControl(ALUControl), .zero(zero),
        .imem_req(imem_req), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .PCSrc(PCSrc), .ALUSrcSel(ALUSrcSel), .ALUOp(ALUOp),
        .RegWriteEn(RegWriteEn), .busy(busy), .halted(halted),
        .state(state), .retired_count(retired_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; imem_ready = 1'b0; opcode = 4'd0;
        RegWrite = 1'b0; ALUSrc = 1'b0; Branch = 1'b0; zero = 1'b0;
        ALUControl = 2'b00;
        #2;
        if (obs !== E_IDLE) begin
            $display("FAIL reset_obs: got %b want %b", obs, E_IDLE); fails++;
        end
        cmps++;
        if ({ALUSrcSel, ALUOp} !== 3'b000) begin
            $display("FAIL reset_ctrl: got %b want 000", {ALUSrcSel, ALUOp});
            fails++;
        end
        cmps++;
        if (retired_count !== 4'd0) begin
            $display("FAIL reset_cnt: got %0d want 0", retired_count); fails++;
        end
        cmps++;
        #10 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_writeback();
        logic [9:0] exp [5];
        exp = '{E_IDLE, E_FRDY, E_DEC, E_EX, E_WB};
        start = 1'b1; imem_ready = 1'b1; RegWrite = 1'b1;
        ALUSrc = 1'b1; ALUControl = 2'b10;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                RegWrite = 1'b0; ALUSrc = 1'b0; ALUControl = 2'b00;
                imem_ready = 1'b0;
            end
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL alu_wb c%0d: got %b want %b", i, obs, exp[i]);
                fails++;
            end
            cmps++;
            if (i == 3) begin
                if ({ALUSrcSel, ALUOp} !== 3'b110) begin
                    $display("FAIL alu_latch: got %b want 110",
                             {ALUSrcSel, ALUOp});
                    fails++;
                end
                cmps++;
            end
            tick();
        end
        if (retired_count !== (PERF ? 4'd1 : 4'd0)) begin
            $display("FAIL alu_cnt: got %0d want %0d", retired_count,
                     PERF ? 1 : 0);
            fails++;
        end
        cmps++;
    endtask

    task automatic test_fetch_wait();
        logic [9:0] exp [6];
        exp = '{E_FWT, E_FWT, E_FWT, E_FRDY, E_DEC, E_EX};
        RegWrite = 1'b0; Branch = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) imem_ready = 1'b1;
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL fetch_wait c%0d: got %b want %b", i, obs, exp[i]);
                fails++;
            end
            cmps++;
            tick();
        end
        if (retired_count !== (PERF ? 4'd2 : 4'd0)) begin
            $display("FAIL wait_cnt: got %0d want %0d", retired_count,
                     PERF ? 2 : 0);
            fails++;
        end
        cmps++;
    endtask

    task automatic test_branch();
        logic [9:0] exp [7];
        exp = '{E_FRDY, E_DEC, E_EXT, E_FRDY, E_DEC, E_EX, E_FRDY};
        Branch = 1'b1; RegWrite = 1'b1; imem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            zero = (i < 3);
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL branch c%0d: got %b want %b", i, obs, exp[i]);
                fails++;
            end
            cmps++;
            if (i < 6) tick();
        end
        if (retired_count !== (PERF ? 4'd4 : 4'd0)) begin
            $display("FAIL br_cnt: got %0d want %0d", retired_count,
                     PERF ? 4 : 0);
            fails++;
        end
        cmps++;
    endtask

    task automatic test_counter_wrap();
        logic [9:0] exp [3];
        exp = '{E_FRDY, E_DEC, E_EX};
        Branch = 1'b0; RegWrite = 1'b0; ALUSrc = 1'b1;
        ALUControl = 2'b01; zero = 1'b0;
        for (int i = 0; i < 39; i++) begin
            #1;
            if (obs !== exp[i % 3]) begin
                $display("FAIL wrap c%0d: got %b want %b", i, obs, exp[i % 3]);
                fails++;
            end
            cmps++;
            tick();
        end
        if (retired_count !== (PERF ? 4'd1 : 4'd0)) begin
            $display("FAIL wrap_cnt: got %0d want %0d", retired_count,
                     PERF ? 1 : 0);
            fails++;
        end
        cmps++;
    endtask

    task automatic test_halt();
        logic [9:0] exp [6];
        exp = '{E_FRDY, E_DEC, E_HALT, E_HALT, E_HALT, E_HALT};
        opcode = 4'b1111; imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start = i[0];
            #1;
            if (obs !== exp[i]) begin
                $display("FAIL halt c%0d: got %b want %b", i, obs, exp[i]);
                fails++;
            end
            cmps++;
            tick();
        end
        if ({ALUSrcSel, ALUOp} !== 3'b101) begin
            $display("FAIL halt_hold: got %b want 101", {ALUSrcSel, ALUOp});
            fails++;
        end
        cmps++;
        if (retired_count !== (PERF ? 4'd1 : 4'd0)) begin
            $display("FAIL halt_cnt: got %0d want %0d", retired_count,
                     PERF ? 1 : 0);
            fails++;
        end
        cmps++;
    endtask

    task automatic test_async_reset();
        #3 rst_n = 1'b0;
        #1;
        if ({obs, ALUSrcSel, ALUOp, retired_count} !== 17'd0) begin
            $display("FAIL rst_halt: got %b want 0",
                     {obs, ALUSrcSel, ALUOp, retired_count});
            fails++;
        end
        cmps++;
        opcode = 4'd0; start = 1'b0; imem_ready = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) start = 1'b1;
            #1;
            if (obs !== E_IDLE) begin
                $display("FAIL rst_idle c%0d: got %b want %b", i, obs, E_IDLE);
                fails++;
            end
            cmps++;
            tick();
        end
        #1;
        if (obs !== E_FWT) begin
            $display("FAIL rst_fetch: got %b want %b", obs, E_FWT); fails++;
        end
        cmps++;
        #2 rst_n = 1'b0;
        #1;
        if (obs !== E_IDLE || imem_req !== 1'b0) begin
            $display("FAIL rst_async: got %b want %b", obs, E_IDLE); fails++;
        end
        cmps++;
        #2 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_fetch_wait();
        test_branch();
        test_counter_wrap();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multi-cycle instruction sequencer for the CPU core. Steps each instruction through fetch, decode, execute and writeback. Latches the combinational decode (RegWrite, ALUSrc, Branch, ALUControl) produced from the instruction register's opcode. Issues the per-cycle enables that drive the PC, IR, ALU and register file, and handshakes with instruction memory.

## Interface
- HALT_OP, 4'b1111, opcode that stops the sequencer in HALT.
- CNT_W, 16, width of the retired-instruction counter.

- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leaves IDLE when sampled high.
- imem_ready  in  1  instruction memory has data for the current request.
- opcode  in  4  opcode from the IR (stable from the cycle after IRWrite).
- RegWrite, ALUSrc, Branch  in  1 each  decode outputs for opcode.
- ALUControl  in  2  decode ALU operation.
- zero  in  1  ALU zero flag, valid in EXECUTE.
- imem_req  out  1  instruction fetch request.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  1  0 = PC+1, 1 = branch target.
- ALUSrcSel  out  1  latched ALUSrc.
- ALUOp  out  2  latched ALUControl.
- RegWriteEn  out  1  register-file write strobe.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
- retired_count  out  CNT_W  instructions retired (see Configuration).

## Operation
- Reset values: state=IDLE, and every output is 0, including latched ctrl and retired_count.
- IDLE: if start=1, go to FETCH.
- FETCH: imem_req=1. Stay while imem_ready=0.
  - When imem_ready=1: IRWrite=1, PCWrite=1, PCSrc=0 for that cycle; go to DECODE.
  - imem_ready outside FETCH is ignored.
- DECODE:
  - If opcode==HALT_OP, go to HALT.
  - Otherwise latch RegWrite, ALUSrc, Branch and ALUControl into internal ctrl registers; go to EXECUTE.
- EXECUTE: ALUSrcSel and ALUOp driven from latched ctrl.
  - Taken branch (latched Branch=1 and zero=1): PCWrite=1, PCSrc=1, retire, go to FETCH.
  - Not-taken branch, or any instruction with latched RegWrite=0: retire, go to FETCH.
  - Latched RegWrite=1 and Branch=0: go to WRITEBACK.
  - Branch=1 with RegWrite=1: branch behaviour wins; no writeback.
- WRITEBACK: RegWriteEn=1 for exactly this cycle; retire; go to FETCH.
- HALT: terminal. Only rst_n exits. start is ignored.
- ALUSrcSel and ALUOp hold the last latched values outside EXECUTE/WRITEBACK. They return to 0 only on reset.
- All strobes (IRWrite, PCWrite, RegWriteEn) are single-cycle Moore outputs of state plus latched ctrl/zero. They are never asserted in IDLE or HALT.

## Timing
- Zero-wait latency:
  - ALU/register-write instruction: 4 cycles (F, D, E, WB).
  - No-write instruction or any branch: 3 cycles.
  - Each imem_ready=0 cycle in FETCH adds 1 cycle.
- IRWrite and PCWrite rise in the same cycle as the imem_ready=1 acceptance. DECODE sees the new opcode on the next cycle.
- Reset mid-operation:
  - rst_n low clears state and outputs asynchronously; imem_req drops without waiting for a clock.
  - Release is synchronous to the next clk edge.
  - After release, the sequencer sits in IDLE until start.
- start held high continuously has no effect beyond the first IDLE exit.

## Configuration
- SEQ_PERF_COUNTER_EN defined:
  - retired_count increments by 1 on each retirement (EXECUTE→FETCH or WRITEBACK→FETCH).
  - Wraps from 2^CNT_W−1 to 0.
  - The HALT instruction is not counted.
- SEQ_PERF_COUNTER_EN undefined: retired_count is tied to 0 and no counter flops exist.

## Test plan
- Reset then start=1, imem_ready=1, opcode=4'b0000 (decode RegWrite=1, ALUControl=2'b00) -> states 1,2,3,4,1; RegWriteEn=1 only in state 4; retired_count=1.
- Fetch with imem_ready low for 3 cycles -> imem_req high 4 cycles; IRWrite/PCWrite pulse once, on the 4th cycle only.
- Branch=1, RegWrite=0, zero=1 in EXECUTE -> PCWrite=1, PCSrc=1 that cycle, next state FETCH. With zero=0 -> PCWrite=0, next state FETCH.
- opcode=4'b1111 in DECODE -> state=5, halted=1, busy=0. start pulses leave the state unchanged and no strobes assert.
- rst_n low while state=FETCH with imem_req=1 -> imem_req=0 before the next clk edge; all outputs 0; state=0.
- SEQ_PERF_COUNTER_EN, CNT_W=4, 17 non-halt instructions -> retired_count=1 after wrap. Without macro -> retired_count stays 0.
